// File: rtl/ldpc_dec_waddr_gen_pkg.sv
// Shared types, base matrix and address table for the LDPC decoder shift-RAM
// read/write address generators.
package ldpc_dec_waddr_gen_pkg;

    localparam int cC_MAX    = 1;
    localparam int cNODE_MAX = 1;
    localparam int cLLR_MAX  = 1;
    localparam int cZ_MAX    = 4;
    localparam int cT_MAX    = 3;
    localparam int cADDR_W   = 8;

    localparam int cT_W    = (cT_MAX > 1) ? $clog2(cT_MAX) : 1;
    localparam int cZ_W    = (cZ_MAX > 1) ? $clog2(cZ_MAX) : 1;
    localparam int cSELA_W = (cLLR_MAX > 1) ? $clog2(cLLR_MAX) : 1;

    typedef logic [cADDR_W-1:0] mem_addr_t;
    typedef logic [cSELA_W-1:0] mem_sela_t;
    typedef logic [cT_W-1:0]    tcnt_t;
    typedef logic [cZ_W-1:0]    zcnt_t;

    // Base matrix row per check block; negative entries are empty blocks
    localparam int cHB [cC_MAX][cNODE_MAX*cT_MAX] = '{'{0, -1, 3}};

    // Word rotation per block; entries of empty blocks are don't-care
    localparam int cSHIFT [cC_MAX][cNODE_MAX][cT_MAX] = '{'{'{0, 1, 3}}};

    typedef struct packed {
        logic      mask;
        zcnt_t     shift;
        mem_sela_t sela;
    } addr_tab_t;

    function automatic addr_tab_t get_addr_tab(int c, int n, int t, int llra);
        addr_tab_t tab;
        tab.mask  = (cHB[c][n*cT_MAX + t] < 0);
        tab.shift = zcnt_t'(cSHIFT[c][n][t] % cZ_MAX);
        tab.sela  = mem_sela_t'((cSHIFT[c][n][t] + llra) % cLLR_MAX);
        return tab;
    endfunction

endpackage

// File: rtl/ldpc_dec_wcnt.sv
// Column-block / word counter pair with precomputed done and zero flags.
// Loop order: permutated (z outer, t inner) or linear (t outer, z inner).
module ldpc_dec_wcnt
    import ldpc_dec_waddr_gen_pkg::*;
#(
    parameter int unsigned pZ = cZ_MAX,
    parameter int unsigned pT = cT_MAX
) (
    input  logic  iclk,
    input  logic  ireset,
    input  logic  iclkena,
    input  logic  iclear,
    input  logic  iincr,
    input  logic  iperm,
    output tcnt_t otcnt,
    output zcnt_t ozcnt,
    output logic  ot_zero,
    output logic  oz_zero,
    output logic  olast,
    output logic  ot_inc,
    output logic  ot_wrap
);

    localparam tcnt_t cT_PRE = tcnt_t'((pT > 1) ? pT - 2 : 0);
    localparam zcnt_t cZ_PRE = zcnt_t'((pZ > 1) ? pZ - 2 : 0);
    localparam logic  cT_ONE = (pT == 1);
    localparam logic  cZ_ONE = (pZ == 1);

    tcnt_t t_q, t_d;
    zcnt_t z_q, z_d;
    logic  t_done_q, t_done_d, t_zero_q, t_zero_d;
    logic  z_done_q, z_done_d, z_zero_q, z_zero_d;
    logic  t_step, z_step;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            t_q      <= '0;
            z_q      <= '0;
            t_done_q <= cT_ONE;
            t_zero_q <= 1'b1;
            z_done_q <= cZ_ONE;
            z_zero_q <= 1'b1;
        end else if (iclkena) begin
            t_q      <= t_d;
            z_q      <= z_d;
            t_done_q <= t_done_d;
            t_zero_q <= t_zero_d;
            z_done_q <= z_done_d;
            z_zero_q <= z_zero_d;
        end
    end

    always_comb begin
        t_d      = t_q;
        z_d      = z_q;
        t_done_d = t_done_q;
        t_zero_d = t_zero_q;
        z_done_d = z_done_q;
        z_zero_d = z_zero_q;
        t_step   = 1'b0;
        z_step   = 1'b0;
        if (iclear) begin
            t_d      = '0;
            z_d      = '0;
            t_done_d = cT_ONE;
            t_zero_d = 1'b1;
            z_done_d = cZ_ONE;
            z_zero_d = 1'b1;
        end else if (iincr) begin
            // The inner counter always steps; the outer one only on inner wrap
            t_step = iperm | z_done_q;
            z_step = ~iperm | t_done_q;
            if (t_step) begin
                if (t_done_q) begin
                    t_d      = '0;
                    t_done_d = cT_ONE;
                    t_zero_d = 1'b1;
                end else begin
                    t_d      = t_q + 1'b1;
                    t_done_d = (t_q == cT_PRE);
                    t_zero_d = 1'b0;
                end
            end
            if (z_step) begin
                if (z_done_q) begin
                    z_d      = '0;
                    z_done_d = cZ_ONE;
                    z_zero_d = 1'b1;
                end else begin
                    z_d      = z_q + 1'b1;
                    z_done_d = (z_q == cZ_PRE);
                    z_zero_d = 1'b0;
                end
            end
        end
    end

    assign otcnt   = t_q;
    assign ozcnt   = z_q;
    assign ot_zero = t_zero_q;
    assign oz_zero = z_zero_q;
    assign olast   = t_done_q & z_done_q;
    assign ot_inc  = t_step & ~t_done_q;
    assign ot_wrap = t_step & t_done_q;

endmodule

// File: rtl/ldpc_dec_waddr_gen.sv
// LDPC decoder write-back address generator: two-stage pipeline producing
// shift-RAM write addresses, enables and inverse-shift selects.
module ldpc_dec_waddr_gen
    import ldpc_dec_waddr_gen_pkg::*;
#(
    parameter int unsigned pC             = 1,
    parameter int unsigned pLLR_BY_CYCLE  = 1,
    parameter int unsigned pNODE_BY_CYCLE = 1,
    parameter int unsigned pZ             = 4,
    parameter int unsigned pT             = 3,
    parameter int unsigned pADDR_W        = 8
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               iclear,
    input  logic               ival,
    input  logic               iload_mode,
    input  logic               ic_nv_mode,
    output logic [pADDR_W-1:0] oaddr [pC][pLLR_BY_CYCLE][pNODE_BY_CYCLE],
    output mem_sela_t          osela [pC][pLLR_BY_CYCLE][pNODE_BY_CYCLE],
    output logic               owen  [pC][pNODE_BY_CYCLE],
    output tcnt_t              otcnt,
    output zcnt_t              ozcnt,
    output logic               odone
);

    localparam logic [cZ_W:0] cZ_VAL = (cZ_W + 1)'(pZ);

    tcnt_t              tcnt;
    zcnt_t              zcnt;
    logic               t_zero, z_zero, last, t_inc, t_wrap, perm;
    logic               unused_z_zero;
    logic [pADDR_W-1:0] tbase_q;

    assign perm          = ic_nv_mode & ~iload_mode;
    assign unused_z_zero = z_zero;

    ldpc_dec_wcnt #(
        .pZ (pZ),
        .pT (pT)
    ) u_wcnt (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .iclear  (iclear),
        .iincr   (ival),
        .iperm   (perm),
        .otcnt   (tcnt),
        .ozcnt   (zcnt),
        .ot_zero (t_zero),
        .oz_zero (z_zero),
        .olast   (last),
        .ot_inc  (t_inc),
        .ot_wrap (t_wrap)
    );

    // Running t*pZ, kept in step with the t counter
    always_ff @(posedge iclk) begin
        if (ireset) begin
            tbase_q <= '0;
        end else if (iclkena) begin
            if (iclear | t_wrap) begin
                tbase_q <= '0;
            end else if (t_inc) begin
                tbase_q <= tbase_q + pADDR_W'(pZ);
            end
        end
    end

    // Stage 1: table lookup, valid and mask
    addr_tab_t          tab_d   [pC][pLLR_BY_CYCLE][pNODE_BY_CYCLE];
    logic               val1_q, last1_q, load1_q, perm1_q;
    tcnt_t              t1_q;
    zcnt_t              z1_q;
    logic [pADDR_W-1:0] tbase1_q;
    zcnt_t              shift1_q [pC][pNODE_BY_CYCLE];
    logic               mask1_q  [pC][pNODE_BY_CYCLE];
    mem_sela_t          sela1_q  [pC][pLLR_BY_CYCLE][pNODE_BY_CYCLE];

    always_comb begin
        for (int unsigned c = 0; c < pC; c++) begin
            for (int unsigned l = 0; l < pLLR_BY_CYCLE; l++) begin
                for (int unsigned n = 0; n < pNODE_BY_CYCLE; n++) begin
                    tab_d[c][l][n] = get_addr_tab(c, n, int'(tcnt), l);
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            val1_q   <= 1'b0;
            last1_q  <= 1'b0;
            load1_q  <= 1'b0;
            perm1_q  <= 1'b0;
            t1_q     <= '0;
            z1_q     <= '0;
            tbase1_q <= '0;
            for (int unsigned c = 0; c < pC; c++) begin
                for (int unsigned n = 0; n < pNODE_BY_CYCLE; n++) begin
                    shift1_q[c][n] <= '0;
                    mask1_q[c][n]  <= 1'b0;
                    for (int unsigned l = 0; l < pLLR_BY_CYCLE; l++) begin
                        sela1_q[c][l][n] <= '0;
                    end
                end
            end
        end else if (iclkena) begin
            // A word coinciding with iclear is dropped
            val1_q   <= ival & ~iclear;
            last1_q  <= last;
            load1_q  <= iload_mode;
            perm1_q  <= perm;
            t1_q     <= tcnt;
            z1_q     <= zcnt;
            tbase1_q <= t_zero ? '0 : tbase_q;
            for (int unsigned c = 0; c < pC; c++) begin
                for (int unsigned n = 0; n < pNODE_BY_CYCLE; n++) begin
                    shift1_q[c][n] <= tab_d[c][0][n].shift;
                    mask1_q[c][n]  <= tab_d[c][0][n].mask;
                    for (int unsigned l = 0; l < pLLR_BY_CYCLE; l++) begin
                        sela1_q[c][l][n] <= perm ? tab_d[c][l][n].sela : mem_sela_t'(l);
                    end
                end
            end
        end
    end

    // Stage 2: mod-add (shift < pZ and z < pZ, so one subtract suffices)
    logic [cZ_W:0]      sum_d  [pC][pNODE_BY_CYCLE];
    zcnt_t              zoff_d [pC][pNODE_BY_CYCLE];
    logic [pADDR_W-1:0] addr_d [pC][pLLR_BY_CYCLE][pNODE_BY_CYCLE];
    logic               wen_d  [pC][pNODE_BY_CYCLE];

    always_comb begin
        for (int unsigned c = 0; c < pC; c++) begin
            for (int unsigned n = 0; n < pNODE_BY_CYCLE; n++) begin
                sum_d[c][n]  = {1'b0, z1_q} + {1'b0, shift1_q[c][n]};
                zoff_d[c][n] = (sum_d[c][n] >= cZ_VAL) ? zcnt_t'(sum_d[c][n] - cZ_VAL)
                                                       : zcnt_t'(sum_d[c][n]);
                wen_d[c][n]  = val1_q & (load1_q | ~mask1_q[c][n]);
                for (int unsigned l = 0; l < pLLR_BY_CYCLE; l++) begin
                    addr_d[c][l][n] = tbase1_q + pADDR_W'(perm1_q ? zoff_d[c][n] : z1_q);
                end
            end
        end
    end

    logic [pADDR_W-1:0] addr_q [pC][pLLR_BY_CYCLE][pNODE_BY_CYCLE];
    mem_sela_t          sela_q [pC][pLLR_BY_CYCLE][pNODE_BY_CYCLE];
    logic               wen_q  [pC][pNODE_BY_CYCLE];
    tcnt_t              tcnt_q;
    zcnt_t              zcnt_q;
    logic               done_q;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            tcnt_q <= '0;
            zcnt_q <= '0;
            done_q <= 1'b0;
            for (int unsigned c = 0; c < pC; c++) begin
                for (int unsigned n = 0; n < pNODE_BY_CYCLE; n++) begin
                    wen_q[c][n] <= 1'b0;
                    for (int unsigned l = 0; l < pLLR_BY_CYCLE; l++) begin
                        addr_q[c][l][n] <= '0;
                        sela_q[c][l][n] <= '0;
                    end
                end
            end
        end else if (iclkena) begin
            tcnt_q <= t1_q;
            zcnt_q <= z1_q;
            done_q <= val1_q & last1_q;
            wen_q  <= wen_d;
            addr_q <= addr_d;
            sela_q <= sela1_q;
        end
    end

    assign oaddr = addr_q;
    assign osela = sela_q;
    assign owen  = wen_q;
    assign otcnt = tcnt_q;
    assign ozcnt = zcnt_q;
    assign odone = done_q;

endmodule

// File: tb/tb_ldpc_dec_waddr_gen.sv
// Scoreboard bench: the driver queues hand-computed expectations, a negedge
// monitor pops and compares them when they fall due.
module tb_ldpc_dec_waddr_gen;
    import ldpc_dec_waddr_gen_pkg::*;

    logic       iclk = 1'b0;
    logic       ireset, iclkena, iclear, ival, iload_mode, ic_nv_mode;
    logic [7:0] oaddr [1][1][1];
    mem_sela_t  osela [1][1][1];
    logic       owen  [1][1];
    tcnt_t      otcnt;
    zcnt_t      ozcnt;
    logic       odone;

    always #5 iclk = ~iclk;

    ldpc_dec_waddr_gen #(
        .pC             (1),
        .pLLR_BY_CYCLE  (1),
        .pNODE_BY_CYCLE (1),
        .pZ             (4),
        .pT             (3),
        .pADDR_W        (8)
    ) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .iclear     (iclear),
        .ival       (ival),
        .iload_mode (iload_mode),
        .ic_nv_mode (ic_nv_mode),
        .oaddr      (oaddr),
        .osela      (osela),
        .owen       (owen),
        .otcnt      (otcnt),
        .ozcnt      (ozcnt),
        .odone      (odone)
    );

    typedef struct {
        int         due;
        string      tag;
        bit         chk_all;
        bit         chk_addr;
        bit         wen;
        bit         done;
        logic [7:0] addr;
        mem_sela_t  sela;
        tcnt_t      t;
        zcnt_t      z;
    } exp_t;

    exp_t sb[$];
    int   cyc  = 0;
    int   nvec = 0;
    int   nmis = 0;

    bit VWEN  [12] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    bit CWEN  [12] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    int CADDR [12] = '{0, 0, 11, 1, 0, 8, 2, 0, 9, 3, 0, 10};

    always @(posedge iclk) cyc <= cyc + 1;

    function automatic exp_t mk_word(string tag, bit wen, bit done, bit chk_addr,
                                     int addr, int t, int z);
        exp_t e;
        e.due = 0; e.tag = tag; e.chk_all = 1'b1; e.chk_addr = chk_addr;
        e.wen = wen; e.done = done; e.addr = 8'(addr); e.sela = '0;
        e.t = tcnt_t'(t); e.z = zcnt_t'(z);
        return e;
    endfunction

    function automatic exp_t mk_bubble(string tag);
        exp_t e;
        e = mk_word(tag, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        e.chk_all = 1'b0;
        return e;
    endfunction

    task automatic drive(input bit v, input bit clr, input bit cn, input bit ld, input exp_t e);
        @(posedge iclk);
        #1;
        ireset     = 1'b0;
        iclkena    = 1'b1;
        ival       = v;
        iclear     = clr;
        ic_nv_mode = cn;
        iload_mode = ld;
        e.due      = cyc + 2;
        sb.push_back(e);
    endtask

    // Reset kills everything not yet visible at the output
    task automatic do_reset();
        exp_t e;
        @(posedge iclk);
        #1;
        ireset = 1'b1;
        ival   = 1'b0;
        iclear = 1'b0;
        while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        e = mk_word("reset", 1'b0, 1'b0, 1'b1, 0, 0, 0);
        e.due = cyc + 1;
        sb.push_back(e);
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    always @(negedge iclk) begin
        exp_t e;
        bit   bad;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            nvec++;
            nmis++;
            $display("FAIL %s: expectation due at cycle %0d never compared (now %0d)",
                     e.tag, e.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e   = sb.pop_front();
            bad = 1'b0;
            nvec++;
            if (owen[0][0] !== e.wen) begin
                bad = 1'b1;
                $display("FAIL %s cyc=%0d: owen=%b want %b", e.tag, cyc, owen[0][0], e.wen);
            end
            if (odone !== e.done) begin
                bad = 1'b1;
                $display("FAIL %s cyc=%0d: odone=%b want %b", e.tag, cyc, odone, e.done);
            end
            if (e.chk_addr && oaddr[0][0][0] !== e.addr) begin
                bad = 1'b1;
                $display("FAIL %s cyc=%0d: oaddr=%0d want %0d", e.tag, cyc, oaddr[0][0][0],
                         e.addr);
            end
            if (e.chk_all && osela[0][0][0] !== e.sela) begin
                bad = 1'b1;
                $display("FAIL %s cyc=%0d: osela=%0d want %0d", e.tag, cyc, osela[0][0][0],
                         e.sela);
            end
            if (e.chk_all && otcnt !== e.t) begin
                bad = 1'b1;
                $display("FAIL %s cyc=%0d: t=%0d want %0d", e.tag, cyc, otcnt, e.t);
            end
            if (e.chk_all && ozcnt !== e.z) begin
                bad = 1'b1;
                $display("FAIL %s cyc=%0d: z=%0d want %0d", e.tag, cyc, ozcnt, e.z);
            end
            if (bad) nmis++;
        end
    end

    initial begin
        ireset = 1'b1; iclkena = 1'b1; iclear = 1'b0; ival = 1'b0;
        iload_mode = 1'b0; ic_nv_mode = 1'b0;
        @(posedge iclk);
        do_reset();

        // vnode: linear order, t=1 block masked
        drive(0, 1, 0, 0, mk_bubble("vnode_clr"));
        for (int i = 0; i < 12; i++)
            drive(1, 0, 0, 0, mk_word("vnode", VWEN[i], i == 11, 1'b1, i, i / 4, i % 4));

        // cnode: permutated order, masked words have don't-care addresses
        drive(0, 1, 1, 0, mk_bubble("cnode_clr"));
        for (int i = 0; i < 12; i++)
            drive(1, 0, 1, 0, mk_word("cnode", CWEN[i], i == 11, CWEN[i], CADDR[i], i % 3, i / 3));

        // load overrides both mask and permutated order
        drive(0, 1, 1, 1, mk_bubble("load_clr"));
        for (int i = 0; i < 12; i++)
            drive(1, 0, 1, 1, mk_word("load", 1'b1, i == 11, 1'b1, i, i / 4, i % 4));

        // cnode with a gap after every word
        drive(0, 1, 1, 0, mk_bubble("toggle_clr"));
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 1, 0, mk_word("toggle", CWEN[i], i == 11, CWEN[i], CADDR[i], i % 3, i / 3));
            drive(0, 0, 1, 0, mk_bubble("toggle_gap"));
        end

        // iclear with the 5th word: word dropped, in-flight words still write
        drive(0, 1, 0, 0, mk_bubble("clr_start"));
        for (int i = 0; i < 4; i++)
            drive(1, 0, 0, 0, mk_word("pre_clr", 1'b1, 1'b0, 1'b1, i, 0, i));
        drive(1, 1, 0, 0, mk_bubble("clr_drop"));
        for (int i = 0; i < 4; i++)
            drive(1, 0, 0, 0, mk_word("post_clr", 1'b1, 1'b0, 1'b1, i, 0, i));

        // ireset mid-pass
        drive(0, 1, 1, 0, mk_bubble("rst_clr"));
        for (int i = 0; i < 5; i++)
            drive(1, 0, 1, 0, mk_word("pre_rst", CWEN[i], 1'b0, CWEN[i], CADDR[i], i % 3, i / 3));
        do_reset();
        drive(1, 0, 1, 0, mk_word("post_rst", 1'b1, 1'b0, 1'b1, 0, 0, 0));
        repeat (3) drive(0, 0, 1, 0, mk_bubble("drain"));

        repeat (4) @(posedge iclk);
        nvec++;
        if (sb.size() != 0) begin
            nmis++;
            $display("FAIL leftover: %0d expectations pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
